// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the result-to-UART streaming blocks.
package uart_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Bytes per frame: data bytes plus the optional sync and sequence bytes.
   function automatic int frame_len(input int w, input bit sync_en, input bit seq_en);
      return (w / 8) + int'(sync_en) + int'(seq_en);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count; storage is not reset, pointers are.
module sync_fifo
   import uart_stream_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage write; data path carries no reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_result_streamer.sv
// Buffers W-bit results and streams each one as a framed byte sequence to a byte UART.
module uart_result_streamer
   import uart_stream_pkg::*;
#(
   parameter int         W         = 32,
   parameter int         DEPTH     = 4,
   parameter bit         MSB_FIRST = 1'b0,
   parameter bit         SYNC_EN   = 1'b1,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter bit         SEQ_EN    = 1'b1,
   localparam int        CW        = clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   input  logic          tx_done,
   output logic          busy,
   output logic [7:0]    frame_seq,
   output logic [CW-1:0] fifo_count
);

   localparam int NBYTES = W / 8;
   localparam int HDR    = int'(SYNC_EN) + int'(SEQ_EN);
   localparam int FLEN   = frame_len(W, SYNC_EN, SEQ_EN);
   localparam int IW     = clog2(FLEN) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_push;
   logic              w_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [W-1:0]      w_fifo_data;
   logic [8*FLEN-1:0] w_frame_load;
   logic [8*FLEN-1:0] r_frame;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_nxt;
   logic              r_tx_start;
   logic [7:0]        r_tx_data;
   logic [7:0]        w_tx_data_nxt;
   logic [7:0]        r_seq;
   logic              w_seq_inc;

   assign w_push     = in_valid & ~w_fifo_full;
   assign in_ready   = ~w_fifo_full;
   assign tx_start   = r_tx_start;
   assign tx_data    = r_tx_data;
   assign busy       = (r_state != IDLE);
   assign frame_seq  = r_seq;

   sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (fifo_count)
   );

   // Lay out the whole frame (sync, sequence, data in wire order) from the FIFO head word.
   always_comb begin
      w_frame_load = '0;
      if (SYNC_EN) w_frame_load[7:0] = SYNC_BYTE;
      if (SEQ_EN)  w_frame_load[8*int'(SYNC_EN) +: 8] = r_seq;
      for (int i = 0; i < NBYTES; i++) begin
         if (MSB_FIRST) w_frame_load[8*(HDR+i) +: 8] = w_fifo_data[W-1-8*i -: 8];
         else           w_frame_load[8*(HDR+i) +: 8] = w_fifo_data[8*i +: 8];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; the byte for the next SEND is chosen here so tx_data is registered with it.
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_idx_nxt     = r_idx;
      w_tx_data_nxt = r_tx_data;
      w_seq_inc     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_idx_nxt     = '0;
               w_tx_data_nxt = w_frame_load[7:0];
               w_state_nxt   = SEND;
            end
         end
         SEND: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (r_idx == LAST_IDX) begin
                  w_seq_inc   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_idx_nxt     = r_idx + 1'b1;
                  w_tx_data_nxt = r_frame[8*int'(w_idx_nxt) +: 8];
                  w_state_nxt   = SEND;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Frame capture on pop; pure data, no reset.
   always_ff @(posedge clk) begin
      if (w_pop) r_frame <= w_frame_load;
   end

   // Control outputs: tx_start is high exactly while the state register holds SEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
         r_idx      <= '0;
         r_seq      <= 8'h00;
      end else begin
         r_tx_start <= (w_state_nxt == SEND);
         r_tx_data  <= w_tx_data_nxt;
         r_idx      <= w_idx_nxt;
         if (w_seq_inc) r_seq <= r_seq + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_result_streamer.sv
// Scoreboard bench: stimulus enqueues expected bytes, monitors pop them on each tx_start.
module tb_uart_result_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Instance A: defaults (W=32, sync + seq, LSB first)
   logic        a_in_valid;
   logic [31:0] a_in_data;
   logic        a_in_ready;
   logic        a_tx_start;
   logic [7:0]  a_tx_data;
   logic        a_tx_done;
   logic        a_busy;
   logic [7:0]  a_frame_seq;
   logic [2:0]  a_fifo_count;
   logic        a_done_m, a_done_s;
   assign a_tx_done = a_done_m | a_done_s;

   // Instance B: W=64, MSB first, no header
   logic        b_in_valid;
   logic [63:0] b_in_data;
   logic        b_in_ready;
   logic        b_tx_start;
   logic [7:0]  b_tx_data;
   logic        b_tx_done;
   logic        b_busy;
   logic [7:0]  b_frame_seq;
   logic [2:0]  b_fifo_count;

   uart_result_streamer u_dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_done(a_tx_done), .busy(a_busy),
      .frame_seq(a_frame_seq), .fifo_count(a_fifo_count)
   );

   uart_result_streamer #(.W(64), .DEPTH(4), .MSB_FIRST(1'b1), .SYNC_EN(1'b0), .SEQ_EN(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_done(b_tx_done), .busy(b_busy),
      .frame_seq(b_frame_seq), .fifo_count(b_fifo_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] a_exp_q[$];
   logic [7:0] b_exp_q[$];
   logic [7:0] a_seq_m = 8'h00;
   int a_starts = 0;
   int b_starts = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Monitor A: every tx_start must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && a_tx_start) begin
         a_starts++;
         if (a_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_extra_start: got byte %0h, expected no tx_start", a_tx_data);
         end else begin
            chk("a_byte", a_tx_data, a_exp_q.pop_front());
         end
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (!rst && b_tx_start) begin
         b_starts++;
         if (b_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_extra_start: got byte %0h, expected no tx_start", b_tx_data);
         end else begin
            chk("b_byte", b_tx_data, b_exp_q.pop_front());
         end
      end
   end

   // UART model A: tx_done 10 cycles after tx_start (counting frozen while stalled).
   bit         a_stall = 1'b0;
   bit         a_pend;
   int         a_cnt;
   logic [7:0] a_cap;
   bit         a_unstable;
   initial begin
      a_done_m = 1'b0;
      a_pend   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         a_done_m = 1'b0;
         if (rst) a_pend = 1'b0;
         else if (a_pend) begin
            if (a_tx_data !== a_cap) a_unstable = 1'b1;
            if (!a_stall) a_cnt++;
            if (a_cnt == 10) begin
               a_done_m = 1'b1;
               a_pend   = 1'b0;
               chk("a_tx_data_stable", a_unstable, 0);
            end
         end
         if (!rst && a_tx_start) begin
            a_pend = 1'b1; a_cnt = 0; a_cap = a_tx_data; a_unstable = 1'b0;
         end
      end
   end

   // UART model B.
   bit         b_pend;
   int         b_cnt;
   logic [7:0] b_cap;
   bit         b_unstable;
   initial begin
      b_tx_done = 1'b0;
      b_pend    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         b_tx_done = 1'b0;
         if (rst) b_pend = 1'b0;
         else if (b_pend) begin
            if (b_tx_data !== b_cap) b_unstable = 1'b1;
            b_cnt++;
            if (b_cnt == 10) begin
               b_tx_done = 1'b1;
               b_pend    = 1'b0;
               chk("b_tx_data_stable", b_unstable, 0);
            end
         end
         if (!rst && b_tx_start) begin
            b_pend = 1'b1; b_cnt = 0; b_cap = b_tx_data; b_unstable = 1'b0;
         end
      end
   end

   task automatic push_a(input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      a_in_valid = 1'b1;
      a_in_data  = d;
      for (int i = 0; i < 3000; i++) begin
         if (a_in_ready) begin ok = 1'b1; break; end
         step();
      end
      if (ok) begin @(posedge clk); #1; end
      a_in_valid = 1'b0;
      chk("a_push_accepted", ok, 1);
   endtask

   task automatic push_frame_a(input logic [31:0] d);
      a_exp_q.push_back(8'hA5);
      a_exp_q.push_back(a_seq_m);
      for (int i = 0; i < 4; i++) a_exp_q.push_back(d[8*i +: 8]);
      a_seq_m = a_seq_m + 8'd1;
      push_a(d);
   endtask

   task automatic push_b(input logic [63:0] d);
      bit ok;
      ok = 1'b0;
      b_in_valid = 1'b1;
      b_in_data  = d;
      for (int i = 0; i < 3000; i++) begin
         if (b_in_ready) begin ok = 1'b1; break; end
         step();
      end
      if (ok) begin @(posedge clk); #1; end
      b_in_valid = 1'b0;
      chk("b_push_accepted", ok, 1);
   endtask

   task automatic wait_idle_a(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (a_exp_q.size() == 0 && !a_busy && a_fifo_count == 0) begin ok = 1'b1; break; end
         step();
      end
      chk("a_idle_within_budget", ok, 1);
   endtask

   task automatic pulse_reset();
      step();
      rst = 1'b1;
      a_exp_q.delete();
      b_exp_q.delete();
      a_seq_m = 8'h00;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit ok;
      int idx;
      logic [31:0] words [6];
      rst        = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_done_s = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0;
      step(); step(); step();

      // Reset values
      chk("rst_tx_start", a_tx_start, 0);
      chk("rst_tx_data", a_tx_data, 8'h00);
      chk("rst_busy", a_busy, 0);
      chk("rst_frame_seq", a_frame_seq, 8'h00);
      chk("rst_fifo_count", a_fifo_count, 3'd0);
      chk("rst_in_ready", a_in_ready, 1);
      rst = 1'b0;
      step();

      // Test 1: one frame A5,00,44,33,22,11 with latency and completion timing
      a_exp_q.push_back(8'hA5); a_exp_q.push_back(8'h00); a_exp_q.push_back(8'h44);
      a_exp_q.push_back(8'h33); a_exp_q.push_back(8'h22); a_exp_q.push_back(8'h11);
      a_seq_m = 8'h01;
      base = a_starts;
      push_a(32'h11223344);
      step();
      chk("t1_no_start_before_pop", a_tx_start, 0);
      chk("t1_count_after_push", a_fifo_count, 3'd1);
      step();
      chk("t1_first_start", a_tx_start, 1);
      chk("t1_first_busy", a_busy, 1);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (a_done_m && a_starts == base + 6) begin ok = 1'b1; break; end
         step();
      end
      chk("t1_final_done_seen", ok, 1);
      chk("t1_busy_during_done", a_busy, 1);
      chk("t1_seq_before_done", a_frame_seq, 8'h00);
      step();
      chk("t1_seq_after_done", a_frame_seq, 8'h01);
      chk("t1_busy_after_done", a_busy, 0);
      chk("t1_start_count", a_starts - base, 6);

      // Test 2: W=64 MSB first, no header -> 01..08
      for (int i = 1; i <= 8; i++) b_exp_q.push_back(8'(i));
      base = b_starts;
      push_b(64'h0102030405060708);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (b_exp_q.size() == 0 && !b_busy) begin ok = 1'b1; break; end
         step();
      end
      chk("t2_done", ok, 1);
      chk("t2_start_count", b_starts - base, 8);
      chk("t2_frame_seq", b_frame_seq, 8'h01);

      // Test 4: spurious tx_done in IDLE, then during SEND
      base = a_starts;
      a_done_s = 1'b1; step(); a_done_s = 1'b0;
      repeat (5) step();
      chk("t4_idle_no_start", a_starts - base, 0);
      chk("t4_idle_not_busy", a_busy, 0);
      push_frame_a(32'hCAFEF00D);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (a_tx_start) begin ok = 1'b1; break; end
         step();
      end
      chk("t4_send_seen", ok, 1);
      a_done_s = 1'b1; step(); a_done_s = 1'b0;
      chk("t4_after_send_no_start", a_tx_start, 0);
      chk("t4_after_send_busy", a_busy, 1);
      wait_idle_a(500);
      chk("t4_start_count", a_starts - base, 6);
      chk("t4_frame_seq", a_frame_seq, 8'h02);

      // Test 3: stalled UART, six offered, five accepted, then drain with seq 00..04
      pulse_reset();
      step();
      words[0] = 32'h00000001; words[1] = 32'h10203040; words[2] = 32'hA0B0C0D0;
      words[3] = 32'h55AA55AA; words[4] = 32'hFFFFFFFF; words[5] = 32'h12345678;
      a_stall = 1'b1;
      idx = 0;
      a_in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         a_in_data = words[idx];
         if (a_in_ready && idx < 6) begin
            a_exp_q.push_back(8'hA5);
            a_exp_q.push_back(a_seq_m);
            for (int i = 0; i < 4; i++) a_exp_q.push_back(words[idx][8*i +: 8]);
            a_seq_m = a_seq_m + 8'd1;
            idx++;
         end
         @(posedge clk);
         #1;
      end
      a_in_valid = 1'b0;
      chk("t3_accepted", idx, 5);
      chk("t3_in_ready_low", a_in_ready, 0);
      chk("t3_fifo_count", a_fifo_count, 3'd4);
      a_stall = 1'b0;
      wait_idle_a(2000);
      chk("t3_frame_seq", a_frame_seq, 8'h05);

      // Test 5: reset during the third data byte, then a fresh frame
      base = a_starts;
      push_frame_a(32'h89ABCDEF);
      push_frame_a(32'h0000BEEF);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (a_starts == base + 5) begin ok = 1'b1; break; end
         step();
      end
      chk("t5_reached_third_data", ok, 1);
      rst = 1'b1;
      a_exp_q.delete();
      a_seq_m = 8'h00;
      step();
      rst = 1'b0;
      chk("t5_tx_start", a_tx_start, 0);
      chk("t5_busy", a_busy, 0);
      chk("t5_fifo_count", a_fifo_count, 3'd0);
      chk("t5_frame_seq", a_frame_seq, 8'h00);
      base = a_starts;
      repeat (20) step();
      chk("t5_abandoned_no_start", a_starts - base, 0);
      a_exp_q.push_back(8'hA5); a_exp_q.push_back(8'h00); a_exp_q.push_back(8'hEF);
      a_exp_q.push_back(8'hBE); a_exp_q.push_back(8'hAD); a_exp_q.push_back(8'hDE);
      a_seq_m = 8'h01;
      push_a(32'hDEADBEEF);
      wait_idle_a(500);
      chk("t5_fresh_frame_count", a_starts - base, 6);
      chk("t5_fresh_seq", a_frame_seq, 8'h01);

      // Test 6: 257 frames, sequence wraps; frame 257 carries 00
      pulse_reset();
      step();
      for (int f = 0; f < 257; f++) push_frame_a(32'(f) * 32'h01010101);
      wait_idle_a(30000);
      chk("t6_seq_wrapped", a_frame_seq, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_result_streamer.md
Name: uart_result_streamer

Overview:
Parametrised successor to the fixed 4-byte result-to-UART sequencer. Accepts W-bit results from any arithmetic core (CORDIC ln, FPU ops) via a valid/ready handshake and buffers them in a small FIFO. Serialises each result into a framed byte stream with an optional sync byte, optional sequence byte and selectable byte order. Drives the existing byte-level Uart transmitter through its TX_START/TX_DATA/TX_DONE handshake.

Parameters:
W, 32, result width in bits; multiple of 8, range 8..64 (NBYTES = W/8)
DEPTH, 4, result FIFO depth in words; power of 2, >= 2
MSB_FIRST, 0, 0 = byte 0 is in_data[7:0]; 1 = byte 0 is in_data[W-1:W-8]
SYNC_EN, 1, 1 = prefix every frame with SYNC_BYTE
SYNC_BYTE, 8'hA5, frame sync value
SEQ_EN, 1, 1 = send the 8-bit frame sequence number after sync

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  result word valid
in_data  in  W  result word
in_ready  out  1  FIFO not full; word accepted on a clk edge where in_valid & in_ready
tx_start  out  1  one-cycle request to Uart
tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_done
tx_done  in  1  Uart byte-complete pulse
busy  out  1  state != IDLE
frame_seq  out  8  sequence number of the next frame to send
fifo_count  out  clog2(DEPTH)+1  words currently buffered

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: tx_start=0, tx_data=0, busy=0, frame_seq=0, fifo_count=0, in_ready=1, state=IDLE. FIFO pointers cleared.
- Reset mid-frame: the frame is abandoned with no further tx_start, and buffered words are discarded.
- FIFO: push on in_valid & in_ready. in_ready = !full and does not depend on a same-cycle pop. Pop only in IDLE. Count updates correctly on simultaneous push and pop.
- Frame: [SYNC_BYTE if SYNC_EN][frame_seq if SEQ_EN][NBYTES data bytes in order set by MSB_FIRST].
- Frame length L = NBYTES + SYNC_EN + SEQ_EN.
- FSM states: IDLE, SEND, WAIT.
- IDLE: if FIFO non-empty, pop into frame register, byte_idx=0, go to SEND. Otherwise stay.
- SEND: tx_start=1 for exactly this cycle, tx_data = byte[byte_idx]. Go to WAIT.
- WAIT: hold tx_data. On tx_done:
  - if byte_idx == L-1: frame_seq <= frame_seq+1 (wraps 255->0), go to IDLE.
  - else: byte_idx+1, go to SEND.
- tx_done while in IDLE or SEND is ignored.
- tx_start is a registered Moore output.
- Latency: word accepted into an empty FIFO at edge k with the FSM in IDLE -> pop at edge k+1 -> tx_start high in the cycle following edge k+1.
- Back-to-back frames: after the last tx_done, IDLE lasts exactly one cycle before the next SEND.
- frame_seq increments only on frame completion, never on pop.

Decomposition:
- Shared package uart_stream_pkg:
  - state encoding (IDLE/SEND/WAIT, 2 bits)
  - default SYNC_BYTE
  - clog2 function
  - frame-length helper function
- Sub-module sync_fifo (W, DEPTH): full/empty/count, synchronous rst. It is reusable by other result-capture blocks.
- Byte selection is an indexed part-select on the frame register; no per-width mux instances.

Test Plan:
1. W=32, defaults; push 32'h11223344. Uart model returns tx_done 10 cycles after each tx_start -> bytes A5,00,44,33,22,11; frame_seq=1 after the final tx_done; busy low one cycle later.
2. MSB_FIRST=1, SYNC_EN=0, SEQ_EN=0, W=64; push 64'h0102030405060708 -> exactly 8 tx_start pulses, bytes 01..08 in order, tx_data stable between each tx_start and its tx_done.
3. DEPTH=4; push 6 words back-to-back while the Uart is stalled (no tx_done) -> in_ready drops after 5 accepted words (4 in FIFO + 1 popped); fifo_count=4. Release the Uart -> all 5 frames sent with seq 00..04 and no word lost or duplicated.
4. Spurious tx_done during IDLE and during the SEND cycle -> no byte advance, no extra tx_start.
5. Assert rst for 1 cycle during the 3rd data byte -> next cycle tx_start=0, busy=0, fifo_count=0, frame_seq=0. The next pushed word produces a complete fresh frame starting with A5,00.
6. Send 257 frames -> frame_seq wraps; the 257th frame carries seq byte 00.
